// File: rtl/vedic_8x8_seq.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 Vedic (Urdhva Tiryagbhyam) core
// over four steps, with valid/ready handshakes on the operand and product sides.

module vedic_2x2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);
    logic w_c1;
    logic w_c2;
    logic w_hi;
    logic w_carry;

    assign w_c1    = i_a[1] & i_b[0];
    assign w_c2    = i_a[0] & i_b[1];
    assign w_hi    = i_a[1] & i_b[1];
    assign w_carry = w_c1 & w_c2;

    assign o_p[0] = i_a[0] & i_b[0];
    assign o_p[1] = w_c1 ^ w_c2;
    assign o_p[2] = w_hi ^ w_carry;
    assign o_p[3] = w_hi & w_carry;
endmodule

module vedic_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0] w_ll;
    logic [3:0] w_hl;
    logic [3:0] w_lh;
    logic [3:0] w_hh;

    vedic_2x2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
    vedic_2x2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
    vedic_2x2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
    vedic_2x2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

    // Cross products land two bit positions up, the high-high product four up.
    assign o_p = {4'b0000, w_ll}
               + {2'b00, w_hl, 2'b00}
               + {2'b00, w_lh, 2'b00}
               + {w_hh, 4'b0000};
endmodule

module vedic_8x8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [1:0]  r_step;
    logic [15:0] r_p;

    logic [3:0]  w_mul_a;
    logic [3:0]  w_mul_b;
    logic [7:0]  w_mul_p;
    logic [15:0] w_pp;
    logic [15:0] w_acc_next;

    // Operand nibbles come only from the latched registers so live inputs cannot leak in.
    always_comb begin
        w_mul_a = r_a[3:0];
        w_mul_b = r_b[3:0];
        case (r_step)
            2'd1:    begin w_mul_a = r_a[7:4]; w_mul_b = r_b[3:0]; end
            2'd2:    begin w_mul_a = r_a[3:0]; w_mul_b = r_b[7:4]; end
            2'd3:    begin w_mul_a = r_a[7:4]; w_mul_b = r_b[7:4]; end
            default: begin w_mul_a = r_a[3:0]; w_mul_b = r_b[3:0]; end
        endcase
    end

    vedic_4x4 u_core (.i_a(w_mul_a), .i_b(w_mul_b), .o_p(w_mul_p));

    always_comb begin
        w_pp = {8'h00, w_mul_p};
        case (r_step)
            2'd1, 2'd2: w_pp = {4'h0, w_mul_p, 4'h0};
            2'd3:       w_pp = {w_mul_p, 8'h00};
            default:    w_pp = {8'h00, w_mul_p};
        endcase
    end

    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 16'h0000;
            r_step  <= 2'd0;
            r_p     <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 16'h0000;
                        r_step  <= 2'd0;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_p     <= w_acc_next;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign p         = r_p;
endmodule

// File: tb/tb_vedic_8x8_seq.sv
// Directed and randomised checks of vedic_8x8_seq: reset, latency, products,
// backpressure, input isolation, mid-operation reset and a scoreboarded random run.

module tb_vedic_8x8_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vedic_8x8_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand pair while the DUT is idle; it is taken on the next rising edge.
    task automatic send(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges after an accept until out_valid appears, giving up after 20.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        #3;
        checks++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ir=%b ov=%b busy=%b p=%h, want ir=1 ov=0 busy=0 p=0000",
                     in_ready, out_valid, busy, p);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        out_ready = 1'b1;
        send(8'h12, 8'h34);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_busy: got busy=%b ir=%b, want busy=1 ir=0", busy, in_ready);
        end
        wait_out(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d edges, want 4", n);
        end
        checks++;
        if (p !== 16'h03A8) begin
            errors++;
            $display("[TB] FAIL basic_product: got %h, want 03a8", p);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_return_idle: got ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors;
        logic [7:0]  va [4] = '{8'hFF, 8'h00, 8'h01, 8'h9C};
        logic [7:0]  vb [4] = '{8'hFF, 8'hA7, 8'h80, 8'h3B};
        logic [15:0] vp [4] = '{16'hFE01, 16'h0000, 16'h0080, 16'h23F4};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i]);
            wait_out(n);
            checks++;
            if (n !== 4 || p !== vp[i]) begin
                errors++;
                $display("[TB] FAIL vector_%0d: got edges=%0d p=%h, want edges=4 p=%h", i, n, p, vp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        send(8'h0F, 8'hF0);
        wait_out(n);
        checks++;
        if (n !== 4 || p !== 16'h0E10) begin
            errors++;
            $display("[TB] FAIL bp_first: got edges=%0d p=%h, want edges=4 p=0e10", n, p);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || p !== 16'h0E10) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d: got ov=%b p=%h, want ov=1 p=0e10", i, out_valid, p);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'h0E10) begin
            errors++;
            $display("[TB] FAIL bp_release: got ir=%b ov=%b p=%h, want ir=1 ov=0 p=0e10", in_ready, out_valid, p);
        end
    endtask

    task automatic test_ignore_inputs;
        int n;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h21;
        b        = 8'h13;
        n        = 0;
        do begin
            @(posedge clk);
            #1;
            a = 8'($urandom);
            b = 8'($urandom);
            n++;
        end while (!out_valid && n < 20);
        checks++;
        if (n !== 5 || p !== 16'h0273) begin
            errors++;
            $display("[TB] FAIL ignore_mul: got edges=%0d p=%h, want edges=5 p=0273", n, p);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            a = 8'($urandom);
            b = 8'($urandom);
        end
        checks++;
        if (out_valid !== 1'b1 || p !== 16'h0273) begin
            errors++;
            $display("[TB] FAIL ignore_done: got ov=%b p=%h, want ov=1 p=0273", out_valid, p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_accept_on_transfer: got ir=%b busy=%b, want ir=1 busy=0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        out_ready = 1'b1;
        send(8'h55, 8'h66);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got ir=%b ov=%b busy=%b p=%h, want ir=1 ov=0 busy=0 p=0000",
                     in_ready, out_valid, busy, p);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 8'h03;
        b        = 8'h05;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_accept_after_reset: got busy=%b, want 1", busy);
        end
        wait_out(n);
        checks++;
        if (n !== 4 || p !== 16'h000F) begin
            errors++;
            $display("[TB] FAIL midreset_product: got edges=%0d p=%h, want edges=4 p=000f", n, p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] expq [$];
        logic [15:0] want;
        int sent   = 0;
        int recv   = 0;
        int cycles = 0;
        bit pending = 0;
        while (recv < 1000 && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            if (!pending && sent < 1000) begin
                a       = 8'($urandom);
                b       = 8'($urandom);
                pending = 1;
            end
            in_valid  = pending && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) begin
                expq.push_back(16'(a) * 16'(b));
                sent++;
                pending = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra_output: got p=%h with no outstanding operation", p);
                end else begin
                    want = expq.pop_front();
                    if (p !== want) begin
                        errors++;
                        $display("[TB] FAIL rand_product_%0d: got %h, want %h", recv, p, want);
                    end
                end
                recv++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (recv !== 1000 || sent !== 1000 || expq.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rand_counts: got sent=%0d recv=%0d left=%0d, want 1000/1000/0",
                     sent, recv, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vedic_8x8_seq.md
VEDIC_8X8_SEQ -- requirements
Module: vedic_8x8_seq

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and built from one shared 4x4 Vedic multiplier instance.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  unsigned multiplicand.
REQ-007 b  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  product on p is valid.
REQ-009 out_ready  input  1  consumer accepts p.
REQ-010 p  output  16  unsigned product a*b, registered.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, MUL, DONE.
REQ-013 in_ready SHALL equal (state==IDLE); a transfer is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 On accept: a and b SHALL be latched into internal operand registers, the 16-bit accumulator SHALL be cleared, the 2-bit step counter SHALL be set to 0, and the state SHALL go to MUL.
REQ-015 In MUL, the shared 4x4 multiplier operands SHALL be selected by step:
- 0: a_lo*b_lo, shift 0
- 1: a_hi*b_lo, shift 4
- 2: a_lo*b_hi, shift 4
- 3: a_hi*b_hi, shift 8
REQ-016 On each MUL edge, the shifted 8-bit partial product SHALL be added to the accumulator mod 2^16 and step SHALL increment. No overflow is possible; the final sum is at most 0xFE01.
REQ-017 On the step-3 edge, p SHALL be loaded with the final accumulator sum and the state SHALL go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly 4 rising edges after the accept edge.
REQ-019 out_valid SHALL equal (state==DONE). p SHALL be held stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 In DONE, an edge with out_ready=1 SHALL complete the output transfer and return the state to IDLE.
REQ-021 A new accept SHALL NOT occur on the same edge as the output transfer; the minimum issue interval is 6 cycles.
REQ-022 in_valid, a and b SHALL be ignored while the state is MUL or DONE; input changes during MUL SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 After an output transfer, p SHALL retain the last product until the next step-3 edge.
REQ-025 The 4x4 multiplier SHALL be the only multiplication resource; its inputs SHALL be muxed from the latched operand registers only.

Reset
REQ-026 While rst_n=0, regardless of clk: state=IDLE, step=0, accumulator=0, operand registers=0, p=0x0000, out_valid=0, busy=0, in_ready=1.
REQ-027 Assertion of rst_n mid-operation (MUL or DONE) SHALL abort the operation with no output handshake.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 Accept a=0x12, b=0x34 with out_ready=1 -> out_valid high 4 edges after accept, p=0x03A8, then in_ready=1 on the next cycle.
REQ-030 a=0xFF, b=0xFF -> p=0xFE01; a=0x00, b=0xA7 -> p=0x0000; a=0x01, b=0x80 -> p=0x0080.
REQ-031 Backpressure: a=0x0F, b=0xF0, out_ready=0 for 5 cycles after out_valid -> p holds 0x0E10 and out_valid stays 1; out_ready=1 -> IDLE on the next edge.
REQ-032 Drive in_valid=1 with changing a/b throughout MUL and DONE -> no extra accept occurs, and the result matches the originally accepted operands.
REQ-033 Pull rst_n low during step 2 of a computation -> outputs take reset values immediately; after release, a=0x03, b=0x05 -> p=0x000F.
REQ-034 Random back-to-back run of 1000 pairs with random in_valid/out_ready -> every p equals a*b, in accept order, with none lost or duplicated.
